// File: rtl/multdiv_stall_controller_pkg.sv
// rtl/multdiv_stall_controller_pkg.sv - shared decode constants and mult/div sequencer state encoding
package multdiv_stall_controller_pkg;

  localparam logic [4:0]  ALU_OPCODE = 5'b00000;
  localparam logic [4:0]  MULT_ALUOP = 5'b00110;
  localparam logic [4:0]  DIV_ALUOP  = 5'b00111;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0000;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_WAIT  = 2'd1,
    MD_DRAIN = 2'd2
  } md_state_e;

endpackage

// File: rtl/multdiv_stall_controller_md_decode.sv
// rtl/multdiv_stall_controller_md_decode.sv - combinational multiply/divide instruction detector
module md_decode #(
  parameter logic [4:0] ALU_OPCODE = multdiv_stall_controller_pkg::ALU_OPCODE,
  parameter logic [4:0] MULT_ALUOP = multdiv_stall_controller_pkg::MULT_ALUOP,
  parameter logic [4:0] DIV_ALUOP  = multdiv_stall_controller_pkg::DIV_ALUOP
) (
  input  logic [31:0] insn,
  output logic        is_mult,
  output logic        is_div
);

  logic is_alu;
  logic unused_insn_bits;

  assign is_alu  = (insn[31:27] == ALU_OPCODE);
  assign is_mult = is_alu && (insn[6:2] == MULT_ALUOP);
  assign is_div  = is_alu && (insn[6:2] == DIV_ALUOP);

  // Register and immediate fields play no part in the decision.
  assign unused_insn_bits = ^{insn[26:7], insn[1:0]};

endmodule

// File: rtl/multdiv_stall_controller.sv
// rtl/multdiv_stall_controller.sv - sequences the multi-cycle mult/div unit and stalls/bubbles the pipeline
module multdiv_stall_controller
  import multdiv_stall_controller_pkg::*;
#(
  parameter logic [4:0] ALU_OPCODE = multdiv_stall_controller_pkg::ALU_OPCODE,
  parameter logic [4:0] MULT_ALUOP = multdiv_stall_controller_pkg::MULT_ALUOP,
  parameter logic [4:0] DIV_ALUOP  = multdiv_stall_controller_pkg::DIV_ALUOP,
  parameter int         TIMEOUT    = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ex_insn,
  input  logic        flush,
  input  logic        unit_ready,
  input  logic        unit_exception,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        xm_bubble,
  output logic        result_sel,
  output logic        exception_out,
  output logic        busy
);

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  md_state_e  state;
  logic [5:0] cnt;
  logic       is_mult;
  logic       is_div;
  logic       is_md;

  md_decode #(
    .ALU_OPCODE(ALU_OPCODE),
    .MULT_ALUOP(MULT_ALUOP),
    .DIV_ALUOP (DIV_ALUOP)
  ) u_md_decode (
    .insn   (ex_insn),
    .is_mult(is_mult),
    .is_div (is_div)
  );

  assign is_md = is_mult || is_div;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (is_md && !flush) begin
            state <= MD_WAIT;
            cnt   <= '0;
          end
        end
        MD_WAIT: begin
          // flush wins over ready, ready wins over timeout
          if (flush)                 state <= MD_DRAIN;
          else if (unit_ready)       state <= MD_IDLE;
          else if (cnt == CNT_LAST)  state <= MD_DRAIN;
          else                       cnt   <= cnt + 6'd1;
        end
        MD_DRAIN: begin
          if (unit_ready) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    ctrl_mult     = 1'b0;
    ctrl_div      = 1'b0;
    stall         = 1'b0;
    xm_bubble     = 1'b0;
    result_sel    = 1'b0;
    exception_out = 1'b0;
    busy          = 1'b0;
    if (reset) begin
      busy = (state != MD_IDLE);
      case (state)
        MD_IDLE: begin
          if (is_md && !flush) begin
            ctrl_mult = is_mult;
            ctrl_div  = is_div;
            stall     = 1'b1;
            xm_bubble = 1'b1;
          end
        end
        MD_WAIT: begin
          if (flush) begin
            xm_bubble = 1'b1;
          end else if (unit_ready) begin
            result_sel    = 1'b1;
            exception_out = unit_exception;
          end else if (cnt == CNT_LAST) begin
            result_sel    = 1'b1;
            exception_out = 1'b1;
          end else begin
            stall     = 1'b1;
            xm_bubble = 1'b1;
          end
        end
        MD_DRAIN: begin
          // A waiting mult/div is held until the abandoned op finishes.
          if (is_md) begin
            stall     = 1'b1;
            xm_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_stall_controller.sv
// tb/tb_multdiv_stall_controller.sv - randomized bench against a behavioural mult/div sequencing model
module tb_multdiv_stall_controller;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ex_insn;
  logic        flush;
  logic        unit_ready;
  logic        unit_exception;
  logic        ctrl_mult, ctrl_div, stall, xm_bubble, result_sel, exception_out, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: does an issued op own the pipeline, is the unit running a discarded op, cycles waited so far
  bit m_owner     = 1'b0;
  bit m_abandoned = 1'b0;
  int m_waited    = 0;

  always #5 clock = ~clock;

  multdiv_stall_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clock         (clock),
    .reset         (reset),
    .ex_insn       (ex_insn),
    .flush         (flush),
    .unit_ready    (unit_ready),
    .unit_exception(unit_exception),
    .ctrl_mult     (ctrl_mult),
    .ctrl_div      (ctrl_div),
    .stall         (stall),
    .xm_bubble     (xm_bubble),
    .result_sel    (result_sel),
    .exception_out (exception_out),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] make_insn(input int md_pct);
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(99) < md_pct) begin
      w[31:27] = 5'd0;
      w[6:2]   = $urandom_range(1) ? 5'd6 : 5'd7;
    end else if ($urandom_range(1) == 1) begin
      w[31:27] = 5'd0;
      w[6:2]   = 5'd0;
    end
    return w;
  endfunction

  task automatic step(input logic rst, input logic [31:0] insn, input logic fl,
                      input logic rdy, input logic uexc);
    logic [4:0] op, aop;
    bit is_mul, is_dv, md;
    logic e_mult, e_div, e_stall, e_bub, e_sel, e_exc, e_busy;
    @(negedge clock);
    reset          = rst;
    ex_insn        = insn;
    flush          = fl;
    unit_ready     = rdy;
    unit_exception = uexc;
    op     = insn[31:27];
    aop    = insn[6:2];
    is_mul = (op == 5'd0) && (aop == 5'd6);
    is_dv  = (op == 5'd0) && (aop == 5'd7);
    md     = is_mul || is_dv;
    {e_mult, e_div, e_stall, e_bub, e_sel, e_exc, e_busy} = '0;
    if (!rst) begin
      m_owner     = 1'b0;
      m_abandoned = 1'b0;
    end else if (m_owner) begin
      e_busy = 1'b1;
      if (fl) begin
        e_bub       = 1'b1;
        m_owner     = 1'b0;
        m_abandoned = 1'b1;
      end else if (rdy) begin
        e_sel   = 1'b1;
        e_exc   = uexc;
        m_owner = 1'b0;
      end else if (m_waited + 1 == TIMEOUT) begin
        e_sel       = 1'b1;
        e_exc       = 1'b1;
        m_owner     = 1'b0;
        m_abandoned = 1'b1;
      end else begin
        e_stall  = 1'b1;
        e_bub    = 1'b1;
        m_waited = m_waited + 1;
      end
    end else if (m_abandoned) begin
      e_busy = 1'b1;
      if (md) begin
        e_stall = 1'b1;
        e_bub   = 1'b1;
      end
      if (rdy) m_abandoned = 1'b0;
    end else if (md && !fl) begin
      e_mult   = is_mul;
      e_div    = is_dv;
      e_stall  = 1'b1;
      e_bub    = 1'b1;
      m_owner  = 1'b1;
      m_waited = 0;
    end
    #1;
    chk("ctrl_mult", ctrl_mult, e_mult);
    chk("ctrl_div", ctrl_div, e_div);
    chk("stall", stall, e_stall);
    chk("xm_bubble", xm_bubble, e_bub);
    chk("result_sel", result_sel, e_sel);
    chk("exception_out", exception_out, e_exc);
    chk("busy", busy, e_busy);
    cyc++;
  endtask

  initial begin
    reset = 1'b0; ex_insn = '0; flush = 1'b0; unit_ready = 1'b0; unit_exception = 1'b0;
    // Reset with a mult/div and ready present: everything must stay quiet.
    step(1'b0, make_insn(100), 1'b0, 1'b1, 1'b1);
    step(1'b0, make_insn(100), 1'b0, 1'b0, 1'b0);
    for (int seg = 0; seg < 28; seg++) begin
      int ready_pct, flush_pct, md_pct, rst_pct;
      case (seg % 4)
        0: ready_pct = 0;
        1: ready_pct = 8;
        2: ready_pct = 35;
        default: ready_pct = 80;
      endcase
      case (seg % 3)
        0: flush_pct = 0;
        1: flush_pct = 4;
        default: flush_pct = 12;
      endcase
      md_pct  = (seg % 2 == 0) ? 85 : 40;
      rst_pct = (seg % 5 == 4) ? 3 : 0;
      for (int i = 0; i < 70; i++) begin
        step(!($urandom_range(99) < rst_pct),
             make_insn(md_pct),
             $urandom_range(99) < flush_pct,
             $urandom_range(99) < ready_pct,
             $urandom_range(1) == 1);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_stall_controller.md
Name: multdiv_stall_controller

Overview:
- Sequences the multi-cycle multiply/divide unit that sits beside the ALU in the execute stage.
- On detecting a mult/div in the D/X latch, it issues a one-cycle start pulse and freezes PC, F/D and D/X.
- While the unit runs, it forces bubbles into the X/M latch.
- When the unit reports ready, it steers the unit result into the X/M latch and releases the pipeline; it also handles timeout, unit exceptions and flush/abort draining.

Parameters:
- ALU_OPCODE, 5'b00000, opcode field insn[31:27] of R-type ALU instructions.
- MULT_ALUOP, 5'b00110, ALU-op field insn[6:2] selecting multiply.
- DIV_ALUOP, 5'b00111, ALU-op field insn[6:2] selecting divide.
- TIMEOUT, 40, WAIT-state cycles without unit_ready before a forced timeout exception; must be 1..63.

Ports:
- clock  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising clock edge resets the block.
- ex_insn  input  32  instruction currently in the D/X latch.
- flush  input  1  abort the in-flight operation (exception/interrupt redirect).
- unit_ready  input  1  multdiv result valid this cycle.
- unit_exception  input  1  multdiv error (overflow, divide-by-zero); qualified by unit_ready.
- ctrl_mult  output  1  one-cycle start-multiply pulse to the unit.
- ctrl_div  output  1  one-cycle start-divide pulse to the unit.
- stall  output  1  hold PC, F/D and D/X (write-enable low).
- xm_bubble  output  1  X/M latch captures a nop and dmem_wr=0.
- result_sel  output  1  X/M alu_out input takes the multdiv result instead of the ALU.
- exception_out  output  1  one-cycle pulse: unit exception or timeout on the current op.
- busy  output  1  state != IDLE.

Behaviour:
- Decode: is_md = (ex_insn[31:27]==ALU_OPCODE) and (ex_insn[6:2] is MULT_ALUOP or DIV_ALUOP).
- States: IDLE, WAIT, DRAIN. Cycle counter cnt is 6 bits.
- All outputs are Mealy, derived from state and current inputs. Every output is 0 in any cycle where reset==0.
- Reset (reset==0 at an edge): state=IDLE and cnt=0 next cycle, regardless of state. Reset mid-operation abandons the unit; the unit is reset by the same line.
- IDLE, is_md & !flush:
  - ctrl_mult or ctrl_div=1 for exactly this cycle.
  - stall=1, xm_bubble=1.
  - Next: WAIT, cnt=0.
- IDLE, otherwise: all outputs 0; stay in IDLE.
- WAIT, flush=1:
  - stall=0, xm_bubble=1, result_sel=0.
  - Next: DRAIN. unit_ready in this same cycle is ignored.
- WAIT, unit_ready=1 (flush=0):
  - result_sel=1, stall=0, xm_bubble=0.
  - exception_out=unit_exception.
  - Next: IDLE. The mult/div advances into X/M at this edge; minimum issue-to-release latency is 2 cycles.
- WAIT, cnt==TIMEOUT-1 and !unit_ready:
  - exception_out=1, result_sel=1 (unit output treated as garbage; rstatus written downstream).
  - stall=0, xm_bubble=0.
  - Next: DRAIN.
- WAIT, otherwise: stall=1, xm_bubble=1, cnt+1; no wrap, since TIMEOUT bounds cnt.
- DRAIN (the unit is still busy with an abandoned op):
  - Start pulses are suppressed.
  - If is_md: stall=1, xm_bubble=1; otherwise outputs 0.
  - When unit_ready=1: result discarded, exception_out=0, next IDLE. If is_md in that same cycle, the new op issues in the following cycle, from IDLE.
- Simultaneous events:
  - flush beats unit_ready.
  - unit_ready beats timeout when both occur in the same cycle.
  - Back-to-back mult/div: the second starts the cycle after release; there is no overlap.
- flush in IDLE: no issue that cycle, even if is_md.

Decomposition:
- Shared package, also used by the decode/ALU control: opcode and ALU-op constants, nop encoding, state encoding (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2).
- One natural sub-module: md_decode, a combinational is_mult/is_div detector reusable by the hazard unit.
- State and counter flops are built from the existing dflipflop/register cells with enable tied high.

Test Plan:
- Mult with unit_ready on the 5th WAIT cycle:
  - ctrl_mult=1 only in the issue cycle.
  - stall=1 and xm_bubble=1 for 5 cycles, then result_sel=1, stall=0 for one cycle.
  - busy returns to 0.
- Div with unit_ready&unit_exception on the 3rd WAIT cycle -> exception_out=1 for exactly that cycle, result_sel=1, then IDLE.
- No unit_ready, TIMEOUT=40:
  - exception_out=1 on WAIT cycle 40, stall released.
  - State goes to DRAIN; a later unit_ready returns to IDLE with no exception_out.
- flush on WAIT cycle 2 with a second mult now in D/X:
  - stall=0 the flush cycle, DRAIN follows.
  - The new mult holds stall=1 until unit_ready, then ctrl_mult pulses the next cycle.
- Reset driven low during WAIT cycle 4 -> all outputs 0 that cycle; busy=0 and state IDLE after the edge; a subsequent add passes with stall=0.
- Two consecutive mults -> two separate ctrl_mult pulses, at least 2 cycles apart, each with its own result_sel cycle.
